// File: rtl/alu_serial_shifter_pkg.sv
// Shared definitions for the serial shifter: op codes, FSM states, flag bundle.
// Also used by the decoder and the ALU result mux.
package alu_serial_shifter_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_SHW   = 4;

    typedef enum logic [1:0] {
        OP_SLA = 2'b00,
        OP_SLR = 2'b01,
        OP_SRL = 2'b10,
        OP_SRA = 2'b11
    } shop_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

    typedef struct packed {
        logic s;
        logic v;
        logic z;
        logic c;
    } flags_t;

endpackage

// File: rtl/alu_shift_step.sv
// One-bit shift/rotate step: next working value, bit shifted out, sign change.
// Purely combinational; the top iterates it once per clock.
module alu_shift_step
    import alu_serial_shifter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  shop_e            op_i,
    input  logic [WIDTH-1:0] w_i,
    output logic [WIDTH-1:0] w_o,
    output logic             bit_o,
    output logic             chg_o
);

    always_comb begin
        w_o   = w_i;
        bit_o = 1'b0;
        unique case (op_i)
            OP_SLA: begin
                w_o   = {w_i[WIDTH-2:0], 1'b0};
                bit_o = w_i[WIDTH-1];
            end
            OP_SLR: begin
                w_o   = {w_i[WIDTH-2:0], w_i[WIDTH-1]};
                bit_o = w_i[WIDTH-1];
            end
            OP_SRL: begin
                w_o   = {1'b0, w_i[WIDTH-1:1]};
                bit_o = w_i[0];
            end
            OP_SRA: begin
                w_o   = {w_i[WIDTH-1], w_i[WIDTH-1:1]};
                bit_o = w_i[0];
            end
            default: begin
                w_o   = w_i;
                bit_o = 1'b0;
            end
        endcase
    end

    assign chg_o = w_o[WIDTH-1] ^ w_i[WIDTH-1];

endmodule

// File: rtl/alu_serial_shifter.sv
// Multi-cycle shifter/rotator, one bit position per clock, start/busy/done.
// Result and S,V,Z,C flags are registered and held until the next completion.
module alu_serial_shifter
    import alu_serial_shifter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SHW   = DEF_SHW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [SHW-1:0]   shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             S,
    output logic             V,
    output logic             Z,
    output logic             C
);

    localparam logic [SHW-1:0] CNT_ONE = {{(SHW-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [SHW-1:0]   cnt_q,   cnt_d;
    logic [WIDTH-1:0] w_q,     w_d;
    shop_e            op_q,    op_d;
    logic             vs_q,    vs_d;
    logic [WIDTH-1:0] res_q,   res_d;
    flags_t           flg_q,   flg_d;

    logic [WIDTH-1:0] step_w;
    logic             step_bit;
    logic             step_chg;

    alu_shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .op_i  (op_q),
        .w_i   (w_q),
        .w_o   (step_w),
        .bit_o (step_bit),
        .chg_o (step_chg)
    );

    // Result/flag registers load on the edge entering DONE, so they are
    // already valid in the cycle done is high.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        w_d     = w_q;
        op_d    = op_q;
        vs_d    = vs_q;
        res_d   = res_q;
        flg_d   = flg_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    op_d  = shop_e'(op);
                    w_d   = in1;
                    cnt_d = shamt;
                    vs_d  = 1'b0;
                    if (shamt != '0) begin
                        state_d = SHIFT;
                    end else begin
                        state_d = DONE;
                        res_d   = in1;
                        flg_d.s = in1[WIDTH-1];
                        flg_d.v = 1'b0;
                        flg_d.z = (in1 == '0);
                        flg_d.c = 1'b0;
                    end
                end
            end
            SHIFT: begin
                w_d   = step_w;
                cnt_d = cnt_q - CNT_ONE;
                vs_d  = vs_q | ((op_q == OP_SLA) & step_chg);
                if (cnt_q == CNT_ONE) begin
                    state_d = DONE;
                    res_d   = step_w;
                    flg_d.s = step_w[WIDTH-1];
                    flg_d.v = vs_d;
                    flg_d.z = (step_w == '0);
                    flg_d.c = step_bit;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            w_q     <= '0;
            op_q    <= OP_SLA;
            vs_q    <= 1'b0;
            res_q   <= '0;
            flg_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            w_q     <= w_d;
            op_q    <= op_d;
            vs_q    <= vs_d;
            res_q   <= res_d;
            flg_q   <= flg_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign out  = res_q;
    assign S    = flg_q.s;
    assign V    = flg_q.v;
    assign Z    = flg_q.z;
    assign C    = flg_q.c;

endmodule
